// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key sequencer: key codes, ALU op
// encodings, sequencer states and small key-classification helpers.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    OP_WAIT  = 3'd1,
    ENTER_B  = 3'd2,
    ISSUE    = 3'd3,
    WAIT_RES = 3'd4,
    SHOW_RES = 3'd5
  } state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'h9;
  endfunction

  function automatic logic is_operator(input logic [3:0] code);
    return (code >= KEY_ADD) && (code <= KEY_DIV);
  endfunction

  // Operator keys are contiguous, so the op is the offset from KEY_ADD.
  function automatic op_e op_of_key(input logic [3:0] code);
    logic [3:0] ofs;
    ofs = code - KEY_ADD;
    return op_e'(ofs[1:0]);
  endfunction

endpackage

// File: rtl/bcd_shift_reg.sv
// One BCD operand register: digit shift-in from the right, whole-value load,
// clear, and a "full" flag (top digit significant) used for overflow.
module bcd_shift_reg
  import calc_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                load_en,
  input  logic [4*NDIG-1:0]   load_val,
  input  logic                shift_en,
  input  logic [3:0]          digit,
  output logic [4*NDIG-1:0]   value,
  output logic                full
);

  // A further digit would push a significant digit off the top.
  assign full = (value[4*NDIG-1 -: 4] != 4'h0);

  // Operand storage; a shift into a full register leaves it unchanged.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      value <= '0;
    end else if (load_en) begin
      value <= load_val;
    end else if (shift_en && !full) begin
      value <= {value[4*NDIG-5:0], digit};
    end
  end

endmodule

// File: rtl/calc_key_sequencer.sv
// Calculator key sequencer: turns filtered keypad events into two BCD
// operands plus an op, hands them to the ALU with a valid/ready handshake,
// and holds the returned result for display.
// Optional feature macro: CALC_CHAIN_EN -- an operator key while a result
// is shown continues the calculation with the result as operand A.
//
// state    | meaning
// ENTER_A  | collecting digits of operand A
// OP_WAIT  | operator chosen, waiting for first digit of B
// ENTER_B  | collecting digits of operand B
// ISSUE    | offering operands/op to the ALU (calc_valid=1)
// WAIT_RES | ALU accepted, waiting for res_valid
// SHOW_RES | displaying the result register
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_event,
  input  logic [3:0]          btn_code,
  output logic [4*NDIG-1:0]   operand_a,
  output logic [4*NDIG-1:0]   operand_b,
  output logic [1:0]          op,
  output logic                calc_valid,
  input  logic                calc_ready,
  input  logic                res_valid,
  input  logic [4*NDIG-1:0]   res_bcd,
  output logic [4*NDIG-1:0]   disp_bcd,
  output logic                ovf
);

  localparam int W = 4 * NDIG;

  state_e         state, state_nxt;
  op_e            op_r, op_nxt;
  logic           ovf_r;
  logic [W-1:0]   result_r;

  logic           key_digit, key_op, key_eq, key_clr;
  logic [W-1:0]   digit_ext;

  logic           clr_all, ovf_set, op_ld, res_ld;
  logic           a_load, a_shift, a_full;
  logic [W-1:0]   a_load_val;
  logic           b_clr, b_load, b_shift, b_full;

  assign key_digit = new_event && is_digit(btn_code);
  assign key_op    = new_event && is_operator(btn_code);
  assign key_eq    = new_event && (btn_code == KEY_EQ);
  assign key_clr   = new_event && (btn_code == KEY_CLR);
  assign digit_ext = {{(W-4){1'b0}}, btn_code};

  bcd_shift_reg #(.NDIG(NDIG)) u_reg_a (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr_all),
    .load_en  (a_load),
    .load_val (a_load_val),
    .shift_en (a_shift),
    .digit    (btn_code),
    .value    (operand_a),
    .full     (a_full)
  );

  bcd_shift_reg #(.NDIG(NDIG)) u_reg_b (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr_all || b_clr),
    .load_en  (b_load),
    .load_val (digit_ext),
    .shift_en (b_shift),
    .digit    (btn_code),
    .value    (operand_b),
    .full     (b_full)
  );

  // State, op, overflow and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ENTER_A;
      op_r     <= OP_ADD;
      ovf_r    <= 1'b0;
      result_r <= '0;
    end else begin
      state <= state_nxt;
      if (op_ld) op_r <= op_nxt;
      if (clr_all) begin
        op_r  <= OP_ADD;
        ovf_r <= 1'b0;
      end else if (ovf_set) begin
        ovf_r <= 1'b1;
      end
      if (res_ld) result_r <= res_bcd;
    end
  end

  // Next-state and register-control decode; clear overrides everything,
  // including a handshake or result arriving in the same cycle.
  always_comb begin
    state_nxt  = state;
    op_nxt     = op_r;
    op_ld      = 1'b0;
    res_ld     = 1'b0;
    ovf_set    = 1'b0;
    clr_all    = 1'b0;
    a_load     = 1'b0;
    a_load_val = digit_ext;
    a_shift    = 1'b0;
    b_clr      = 1'b0;
    b_load     = 1'b0;
    b_shift    = 1'b0;
    if (key_clr) begin
      clr_all   = 1'b1;
      state_nxt = ENTER_A;
    end else begin
      case (state)
        ENTER_A: begin
          if (key_digit) begin
            a_shift = 1'b1;
            ovf_set = a_full;
          end else if (key_op) begin
            op_ld     = 1'b1;
            op_nxt    = op_of_key(btn_code);
            state_nxt = OP_WAIT;
          end
        end
        OP_WAIT: begin
          if (key_op) begin
            op_ld  = 1'b1;
            op_nxt = op_of_key(btn_code);
          end else if (key_digit) begin
            b_load    = 1'b1;
            state_nxt = ENTER_B;
          end
        end
        ENTER_B: begin
          if (key_digit) begin
            b_shift = 1'b1;
            ovf_set = b_full;
          end else if (key_eq) begin
            state_nxt = ISSUE;
          end
        end
        ISSUE: begin
          if (calc_ready) state_nxt = WAIT_RES;
        end
        WAIT_RES: begin
          if (res_valid) begin
            res_ld    = 1'b1;
            state_nxt = SHOW_RES;
          end
        end
        SHOW_RES: begin
          if (key_digit) begin
            a_load    = 1'b1;
            b_clr     = 1'b1;
            state_nxt = ENTER_A;
          end
`ifdef CALC_CHAIN_EN
          else if (key_op) begin
            a_load     = 1'b1;
            a_load_val = result_r;
            op_ld      = 1'b1;
            op_nxt     = op_of_key(btn_code);
            state_nxt  = OP_WAIT;
          end
`endif
        end
        default: state_nxt = ENTER_A;
      endcase
    end
  end

  // Display source follows which value the user is currently working on.
  always_comb begin
    disp_bcd = operand_a;
    case (state)
      ENTER_B, ISSUE, WAIT_RES: disp_bcd = operand_b;
      SHOW_RES:                 disp_bcd = result_r;
      default:                  disp_bcd = operand_a;
    endcase
  end

  assign calc_valid = (state == ISSUE);
  assign op         = op_r;
  assign ovf        = ovf_r;

endmodule

// File: doc/calc_key_sequencer.md
CALC_KEY_SEQUENCER -- requirements
Module: calc_key_sequencer

Interface
REQ-001 SHALL have parameter NDIG, default 4: number of BCD digits per operand.
REQ-002 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port new_event, input, 1: one-cycle pulse from the keypad anti-repeat stage marking a new filtered key.
REQ-005 SHALL have port btn_code, input, 4: key id, valid when new_event=1; 0x0-0x9 digit, 0xA add, 0xB sub, 0xC mul, 0xD div, 0xE clear, 0xF equals.
REQ-006 SHALL have port operand_a, output, 4*NDIG: BCD operand A.
REQ-007 SHALL have port operand_b, output, 4*NDIG: BCD operand B.
REQ-008 SHALL have port op, output, 2: 00 add, 01 sub, 10 mul, 11 div.
REQ-009 SHALL have port calc_valid, output, 1: operands and op are offered to the ALU.
REQ-010 SHALL have port calc_ready, input, 1: ALU accepts; transfer occurs when calc_valid and calc_ready are both 1.
REQ-011 SHALL have port res_valid, input, 1: one-cycle pulse with the ALU result.
REQ-012 SHALL have port res_bcd, input, 4*NDIG: ALU result, BCD.
REQ-013 SHALL have port disp_bcd, output, 4*NDIG: value to display.
REQ-014 SHALL have port ovf, output, 1: sticky digit-overflow flag.

Function
REQ-015 SHALL implement states ENTER_A, OP_WAIT, ENTER_B, ISSUE, WAIT_RES, SHOW_RES.
REQ-016 ENTER_A, digit key: operand_a <= {operand_a[4*NDIG-5:0], digit}, next cycle.
REQ-017 ENTER_A, operator key: latch op, go to OP_WAIT; equals ignored.
REQ-018 OP_WAIT, operator key: replace op; digit key: operand_b <= digit, go to ENTER_B; equals ignored.
REQ-019 ENTER_B, digit key: shift into operand_b as REQ-016; operator ignored; equals: go to ISSUE.
REQ-020 ISSUE: calc_valid=1, operands and op stable until handshake; on handshake go to WAIT_RES next cycle.
REQ-021 WAIT_RES: on res_valid capture res_bcd into result register, go to SHOW_RES.
REQ-022 SHOW_RES, digit key: operand_a <= digit, operand_b <= 0, go to ENTER_A.
REQ-023 Digit key when the target operand already has NDIG significant digits (top nibble nonzero): operand unchanged, ovf <= 1.
REQ-024 Digit keys, operator keys and equals in ISSUE or WAIT_RES: ignored.
REQ-025 Clear key in any state: operand_a, operand_b, op, ovf <= 0, calc_valid <= 0, state <= ENTER_A next cycle; overrides a pending handshake.
REQ-026 Clear coincident with res_valid: clear wins; result is discarded.
REQ-027 disp_bcd: operand_a in ENTER_A/OP_WAIT, operand_b in ENTER_B/ISSUE/WAIT_RES, result register in SHOW_RES.
REQ-028 Key-to-register latency: exactly one clk cycle after the new_event cycle.

Reset
REQ-029 On reset: state ENTER_A; operand_a, operand_b, result register, disp_bcd all 0; op=00; calc_valid=0; ovf=0.
REQ-030 Reset mid-handshake SHALL drop calc_valid in the next cycle regardless of calc_ready.

Configuration
REQ-031 Macro CALC_CHAIN_EN, when defined: operator key in SHOW_RES loads operand_a <= result, latches op, goes to OP_WAIT.
REQ-032 Without CALC_CHAIN_EN: operator key in SHOW_RES is ignored.

Structure
REQ-033 Key-code constants, op encodings and state enumeration SHALL reside in shared package calc_pkg.
REQ-034 BCD digit-shift plus overflow detection SHALL be one sub-module, bcd_shift_reg, instantiated for operand A and operand B.

Verification
REQ-035 Keys 1,2,A,3,F, calc_ready=1 -> calc_valid one cycle, operand_a=0x0012, operand_b=0x0003, op=00.
REQ-036 Keys 1,2,3,4,5 -> operand_a=0x1234, ovf=1; then E -> all 0, ovf=0.
REQ-037 Keys 9,B,C,5,F with calc_ready=0 for 10 cycles -> op=10, calc_valid held 10 cycles, operands stable.
REQ-038 After REQ-035, res_valid with res_bcd=0x0015 -> disp_bcd=0x0015; key A -> operand_a=0x0015 with CALC_CHAIN_EN, no change without it.
REQ-039 In ISSUE, key E with calc_ready=0 -> calc_valid=0 next cycle, state ENTER_A; later res_valid ignored.
